pipeline_control: RTL and testbench

- Generates the `stall` and `flush` controls that the superscalar core consumes, plus the front-end PC redirect.
- In the assembled core, `Assembled_Superscalar` currently takes `stall` and `flush` as top-level inputs. This block becomes their source once it is instantiated at the core top.
- Sits between commit (mispredict reports), the structural-occupancy signals (ROB/RRF/RS/SB full) and fetch (redirect).

---
 rtl/pipeline_control.sv | 109 ++++++++++
 tb/tb_pipeline_control.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Stall/flush/redirect sequencer for the superscalar core.
// Optional performance counters are enabled with PIPE_CTRL_PERF_EN.
module pipeline_control #(
  parameter int unsigned          PC_WIDTH     = 16,
  parameter int unsigned          FLUSH_CYCLES = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ext_stall,
  input  logic                rob_full,
  input  logic                rrf_full,
  input  logic                rs_al_full,
  input  logic                rs_ls_full,
  input  logic                sb_full,
  input  logic [1:0]          commit_mispred,
  input  logic [PC_WIDTH-1:0] commit_target0,
  input  logic [PC_WIDTH-1:0] commit_target1,
  output logic                stall,
  output logic                flush,
  output logic                redirect_valid,
  output logic [PC_WIDTH-1:0] redirect_pc
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [15:0]         flush_events
`endif
);

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {StRun, StFlush, StRedirect} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                full_any;
  logic                mispred_take;

  assign full_any    = ext_stall | rob_full | rrf_full | rs_al_full | rs_ls_full | sb_full;
  assign redirect_pc = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFlush;
      cnt_q   <= FlushInit;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    stall          = 1'b1;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    mispred_take   = 1'b0;
    case (state_q)
      StRun: begin
        stall = full_any;
        if (commit_mispred != 2'b00) begin
          mispred_take = 1'b1;
          state_d      = StFlush;
          cnt_d        = FlushInit;
          // Slot 0 is older, so it wins when both slots mispredict.
          pc_d         = commit_mispred[0] ? commit_target0 : commit_target1;
        end
      end
      StFlush: begin
        flush = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        redirect_valid = 1'b1;
        state_d        = StRun;
      end
      default: begin
        flush   = 1'b1;
        state_d = StFlush;
        cnt_d   = FlushInit;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if ((state_q == StRun) && stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (mispred_take && (flush_events != '1)) begin
        flush_events <= flush_events + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control (FLUSH_CYCLES=2, RESET_PC=0x0040).
module tb_pipeline_control;

  logic        clk;
  logic        reset;
  logic        ext_stall, rob_full, rrf_full, rs_al_full, rs_ls_full, sb_full;
  logic [1:0]  commit_mispred;
  logic [15:0] commit_target0, commit_target1;
  logic        stall, flush, redirect_valid;
  logic [15:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_control #(
    .PC_WIDTH    (16),
    .FLUSH_CYCLES(2),
    .RESET_PC    (16'h0040)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ext_stall     (ext_stall),
    .rob_full      (rob_full),
    .rrf_full      (rrf_full),
    .rs_al_full    (rs_al_full),
    .rs_ls_full    (rs_ls_full),
    .sb_full       (sb_full),
    .commit_mispred(commit_mispred),
    .commit_target0(commit_target0),
    .commit_target1(commit_target1),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b0;
    {ext_stall, rob_full, rrf_full, rs_al_full, rs_ls_full, sb_full} = '0;
    commit_mispred = 2'b00;
    commit_target0 = '0;
    commit_target1 = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({stall, flush, redirect_valid} !== 3'b110 || redirect_pc !== 16'h0040) begin
        errors++;
        $display("FAIL reset_hold[%0d]: s/f/rv=%b pc=%h want 110 0040", i,
                 {stall, flush, redirect_valid}, redirect_pc);
      end
    end
    @(negedge clk); reset = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({stall, flush, redirect_valid} !== 3'b110) begin
        errors++;
        $display("FAIL reset_flush[%0d]: s/f/rv=%b want 110", i, {stall, flush, redirect_valid});
      end
      @(negedge clk); #1;
    end
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b101 || redirect_pc !== 16'h0040) begin
      errors++;
      $display("FAIL reset_redirect: s/f/rv=%b pc=%h want 101 0040",
               {stall, flush, redirect_valid}, redirect_pc);
    end
    @(negedge clk); #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_run: s/f/rv=%b want 000", {stall, flush, redirect_valid});
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rob_full  = (i < 3);
      sb_full   = (i == 3);
      ext_stall = (i == 3);
      #1;
      checks++;
      if ({stall, flush, redirect_valid} !== 3'b100) begin
        errors++;
        $display("FAIL stall_on[%0d]: s/f/rv=%b want 100", i, {stall, flush, redirect_valid});
      end
    end
    @(negedge clk);
    {ext_stall, rob_full, sb_full} = '0;
    #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b000) begin
      errors++;
      $display("FAIL stall_off: s/f/rv=%b want 000", {stall, flush, redirect_valid});
    end
  endtask

  task automatic test_mispred(input logic [1:0] mp, input logic [15:0] t0, input logic [15:0] t1,
                              input logic [15:0] exp_pc);
    @(negedge clk);
    commit_mispred = mp;
    commit_target0 = t0;
    commit_target1 = t1;
    #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b000) begin
      errors++;
      $display("FAIL mp%b_run: s/f/rv=%b want 000", mp, {stall, flush, redirect_valid});
    end
    @(negedge clk); commit_mispred = 2'b00; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({stall, flush, redirect_valid} !== 3'b110) begin
        errors++;
        $display("FAIL mp%b_flush[%0d]: s/f/rv=%b want 110", mp, i, {stall, flush, redirect_valid});
      end
      @(negedge clk); #1;
    end
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b101 || redirect_pc !== exp_pc) begin
      errors++;
      $display("FAIL mp%b_redirect: s/f/rv=%b pc=%h want 101 %h", mp,
               {stall, flush, redirect_valid}, redirect_pc, exp_pc);
    end
    @(negedge clk); #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b000 || redirect_pc !== exp_pc) begin
      errors++;
      $display("FAIL mp%b_resume: s/f/rv=%b pc=%h want 000 %h", mp,
               {stall, flush, redirect_valid}, redirect_pc, exp_pc);
    end
  endtask

  task automatic test_ignore();
    @(negedge clk); commit_mispred = 2'b01; commit_target0 = 16'h0300; #1;
    @(negedge clk); commit_target0 = 16'h0999; commit_target1 = 16'h0888; #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b110) begin
      errors++;
      $display("FAIL ign_flush0: s/f/rv=%b want 110", {stall, flush, redirect_valid});
    end
    @(negedge clk); commit_mispred = 2'b00; #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b110) begin
      errors++;
      $display("FAIL ign_flush1: s/f/rv=%b want 110", {stall, flush, redirect_valid});
    end
    @(negedge clk); commit_mispred = 2'b01; #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b101 || redirect_pc !== 16'h0300) begin
      errors++;
      $display("FAIL ign_redirect: s/f/rv=%b pc=%h want 101 0300",
               {stall, flush, redirect_valid}, redirect_pc);
    end
    @(negedge clk); commit_mispred = 2'b00; #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b000 || redirect_pc !== 16'h0300) begin
      errors++;
      $display("FAIL ign_resume: s/f/rv=%b pc=%h want 000 0300",
               {stall, flush, redirect_valid}, redirect_pc);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); commit_mispred = 2'b01; commit_target0 = 16'h0ABC; #1;
    @(negedge clk); commit_mispred = 2'b00; #1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b110 || redirect_pc !== 16'h0040) begin
      errors++;
      $display("FAIL arst_now: s/f/rv=%b pc=%h want 110 0040",
               {stall, flush, redirect_valid}, redirect_pc);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 16'd0) begin
      errors++;
      $display("FAIL arst_perf: stall_cycles=%0d flush_events=%0d want 0 0",
               stall_cycles, flush_events);
    end
`endif
    @(negedge clk); reset = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({stall, flush, redirect_valid} !== 3'b110) begin
        errors++;
        $display("FAIL arst_flush[%0d]: s/f/rv=%b want 110", i, {stall, flush, redirect_valid});
      end
      @(negedge clk); #1;
    end
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b101 || redirect_pc !== 16'h0040) begin
      errors++;
      $display("FAIL arst_redirect: s/f/rv=%b pc=%h want 101 0040",
               {stall, flush, redirect_valid}, redirect_pc);
    end
    @(negedge clk); #1;
    checks++;
    if ({stall, flush, redirect_valid} !== 3'b000) begin
      errors++;
      $display("FAIL arst_run: s/f/rv=%b want 000", {stall, flush, redirect_valid});
    end
  endtask

  task automatic test_stall_sources();
    logic [5:0] vec;
    for (int i = 0; i < 6; i++) begin
      vec = 6'd1 << i;
      @(negedge clk);
      {ext_stall, rob_full, rrf_full, rs_al_full, rs_ls_full, sb_full} = vec;
      #1;
      checks++;
      if (stall !== 1'b1 || flush !== 1'b0) begin
        errors++;
        $display("FAIL stall_src[%0d]: stall=%b flush=%b want 1 0", i, stall, flush);
      end
    end
    @(negedge clk);
    {ext_stall, rob_full, rrf_full, rs_al_full, rs_ls_full, sb_full} = '0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_src_off: stall=%b want 0", stall);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_mispred(2'b10, 16'h5555, 16'h1234, 16'h1234);
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd4 || flush_events !== 16'd1) begin
      errors++;
      $display("FAIL perf: stall_cycles=%0d flush_events=%0d want 4 1",
               stall_cycles, flush_events);
    end
`endif
    test_mispred(2'b11, 16'h0100, 16'h0200, 16'h0100);
    test_ignore();
    test_async_reset();
    test_stall_sources();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
